// File: rtl/switch_debounce_ctrl_if.sv
// Memory-mapped slave bus for the switch debounce controller.
// The master drives select/strobes/address/write data; the slave returns
// registered read data with a one-cycle valid pulse.
interface switch_debounce_ctrl_if;
    logic        iChip_select_n;
    logic        iRead_n;
    logic        iWrite_n;
    logic [1:0]  iAddress;
    logic [15:0] iWritedata;
    logic [15:0] oReaddata;
    logic        oReaddata_valid;

    modport master (
        output iChip_select_n, iRead_n, iWrite_n, iAddress, iWritedata,
        input  oReaddata, oReaddata_valid
    );

    modport slave (
        input  iChip_select_n, iRead_n, iWrite_n, iAddress, iWritedata,
        output oReaddata, oReaddata_valid
    );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Slide-switch front end: 2-FF synchroniser, one shared debounce counter
// and snapshot for all switches, per-switch change flags with a maskable
// level interrupt, and a DATA/EDGE/MASK/STATUS register file.
module switch_debounce_ctrl #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                  iClk,
    input  logic                  iReset_n,
    switch_debounce_ctrl_if.slave bus,
    input  logic [N_SW-1:0]       iSwitches_data,
    output logic                  oIrq
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETTLE = 2'b01;
    localparam logic [1:0] COMMIT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  swMeta_p0;
    logic [N_SW-1:0]  swSync_p1;
    logic [N_SW-1:0]  dataReg;
    logic [N_SW-1:0]  edgeReg;
    logic [N_SW-1:0]  maskReg;
    logic [N_SW-1:0]  snapshot;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;

    logic             readAcc;
    logic             writeAcc;
    logic [N_SW-1:0]  edgeClr;
    logic [N_SW-1:0]  edgeSet;
    logic [15:0]      rdMux;

    assign readAcc  = !bus.iChip_select_n && !bus.iRead_n;
    assign writeAcc = !bus.iChip_select_n && !bus.iWrite_n;

    // W1C clear mask from the bus, and the change bits a commit is about to raise.
    always_comb begin
        edgeClr = '0;
        edgeSet = '0;
        if (writeAcc && bus.iAddress == 2'd1) begin
            edgeClr = bus.iWritedata[N_SW-1:0];
        end
        if (state == COMMIT) begin
            edgeSet = dataReg ^ snapshot;
        end
    end

    // Register read mux; unused upper bits read as zero.
    always_comb begin
        rdMux = 16'h0000;
        case (bus.iAddress)
            2'd0:    rdMux = 16'(dataReg);
            2'd1:    rdMux = 16'(edgeReg);
            2'd2:    rdMux = 16'(maskReg);
            default: rdMux = {13'd0, state, state != IDLE};
        endcase
    end

    // Two-flop synchroniser for the raw asynchronous switch levels.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            swMeta_p0 <= '0;
            swSync_p1 <= '0;
        end else begin
            swMeta_p0 <= iSwitches_data;
            swSync_p1 <= swMeta_p0;
        end
    end

    // Shared debounce FSM: any change restarts the whole window; returning to
    // the committed level abandons the pending change. The counter stops at
    // its terminal value, so it can never wrap.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            snapshot <= '0;
            dataReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (swSync_p1 != dataReg) begin
                        snapshot <= swSync_p1;
                        cnt      <= '0;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (swSync_p1 == dataReg) begin
                        state <= IDLE;
                    end else if (swSync_p1 != snapshot) begin
                        snapshot <= swSync_p1;
                        cnt      <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    dataReg <= snapshot;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // EDGE flags (a same-cycle set beats the W1C clear) and the MASK register.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            edgeReg <= '0;
            maskReg <= '0;
        end else begin
            edgeReg <= (edgeReg & ~edgeClr) | edgeSet;
            if (writeAcc && bus.iAddress == 2'd2) begin
                maskReg <= bus.iWritedata[N_SW-1:0];
            end
        end
    end

    // Registered read response (pre-write values) and level interrupt.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            bus.oReaddata       <= 16'h0000;
            bus.oReaddata_valid <= 1'b0;
            oIrq                <= 1'b0;
        end else begin
            if (readAcc) begin
                bus.oReaddata <= rdMux;
            end
            bus.oReaddata_valid <= readAcc;
            oIrq                <= |(edgeReg & maskReg);
        end
    end

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl (N_SW=10, DEBOUNCE_CYCLES=16).
// A run-length model of the debounce rule tracks every output each cycle;
// directed reads pin the model against hand-derived register values.
module tb_switch_debounce_ctrl;
    localparam int N_SW = 10;
    localparam int DEB  = 16;

    logic            iClk;
    logic            iReset_n;
    logic [N_SW-1:0] sw;
    logic            irq;

    switch_debounce_ctrl_if bus ();

    switch_debounce_ctrl #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (5)
    ) dut (
        .iClk           (iClk),
        .iReset_n       (iReset_n),
        .bus            (bus),
        .iSwitches_data (sw),
        .oIrq           (irq)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: the synchronised level is the input delayed two clocks;
    // a commit happens once the synchronised level has sat on one value
    // different from DATA for DEB+1 consecutive samples, and lands one clock later.
    logic [N_SW-1:0] mSync1 = '0, mSync2 = '0;
    logic [N_SW-1:0] mData = '0, mEdge = '0, mMask = '0, mCand = '0;
    int              mRun  = 0;
    bit              mPend = 1'b0;
    logic [15:0]     mRd   = '0;
    logic            mVld  = 1'b0;
    logic            mIrq  = 1'b0;

    initial forever begin : model
        logic [15:0]     rdVal;
        logic [15:0]     stat;
        logic [N_SW-1:0] clr, setb, s;
        logic            irqNext;
        bit              rdAcc, wrAcc;
        @(posedge iClk or negedge iReset_n);
        if (!iReset_n) begin
            mSync1 = '0; mSync2 = '0; mData = '0; mEdge = '0; mMask = '0;
            mCand = '0; mRun = 0; mPend = 1'b0; mRd = '0; mVld = 1'b0; mIrq = 1'b0;
        end else begin
            rdAcc = !bus.iChip_select_n && !bus.iRead_n;
            wrAcc = !bus.iChip_select_n && !bus.iWrite_n;
            stat  = mPend ? 16'h0005 : ((mRun > 0) ? 16'h0003 : 16'h0000);
            case (bus.iAddress)
                2'd0:    rdVal = 16'(mData);
                2'd1:    rdVal = 16'(mEdge);
                2'd2:    rdVal = 16'(mMask);
                default: rdVal = stat;
            endcase
            if (rdAcc) mRd = rdVal;
            mVld    = rdAcc;
            irqNext = |(mEdge & mMask);
            clr     = (wrAcc && bus.iAddress == 2'd1) ? bus.iWritedata[N_SW-1:0] : '0;
            setb    = '0;
            if (mPend) begin
                setb  = mData ^ mCand;
                mData = mCand;
                mRun  = 0;
                mPend = 1'b0;
            end else begin
                s = mSync2;
                if (s == mData) mRun = 0;
                else if (mRun > 0 && s == mCand) mRun++;
                else begin
                    mCand = s;
                    mRun  = 1;
                end
                if (mRun == DEB + 1) mPend = 1'b1;
            end
            mEdge = (mEdge & ~clr) | setb;
            if (wrAcc && bus.iAddress == 2'd2) mMask = bus.iWritedata[N_SW-1:0];
            mIrq   = irqNext;
            mSync2 = mSync1;
            mSync1 = sw;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    initial forever begin : compare
        @(negedge iClk);
        if (chkEn) begin
            check("cyc_readdata", bus.oReaddata, mRd);
            check("cyc_valid", {15'd0, bus.oReaddata_valid}, {15'd0, mVld});
            check("cyc_irq", {15'd0, irq}, {15'd0, mIrq});
        end
    end

    task automatic busRead(input logic [1:0] a, output logic [15:0] d);
        bus.iChip_select_n = 1'b0;
        bus.iRead_n        = 1'b0;
        bus.iAddress       = a;
        @(negedge iClk);
        bus.iChip_select_n = 1'b1;
        bus.iRead_n        = 1'b1;
        check("rd_valid_pulse", {15'd0, bus.oReaddata_valid}, 16'd1);
        d = bus.oReaddata;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [15:0] v);
        bus.iChip_select_n = 1'b0;
        bus.iWrite_n       = 1'b0;
        bus.iAddress       = a;
        bus.iWritedata     = v;
        @(negedge iClk);
        bus.iChip_select_n = 1'b1;
        bus.iWrite_n       = 1'b1;
    endtask

    logic [15:0] d;

    initial begin : stimulus
        bus.iChip_select_n = 1'b1;
        bus.iRead_n        = 1'b1;
        bus.iWrite_n       = 1'b1;
        bus.iAddress       = 2'd0;
        bus.iWritedata     = 16'h0000;
        sw                 = '0;
        iReset_n           = 1'b0;
        repeat (3) @(negedge iClk);
        chkEn    = 1'b1;
        iReset_n = 1'b1;

        // Reset state of every register.
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), d);
            check("reset_reg", d, 16'h0000);
        end
        @(negedge iClk);
        check("valid_one_cycle", {15'd0, bus.oReaddata_valid}, 16'd0);
        check("reset_irq", {15'd0, irq}, 16'd0);

        // Bit0 bounces in 5-cycle windows; nothing may commit until it holds.
        for (int w = 0; w < 12; w++) begin
            sw = {9'd0, (w % 2 == 0)};
            busRead(2'd0, d);
            check("bounce_data_hold", d, 16'h0000);
            repeat (4) @(negedge iClk);
        end
        sw = 10'h001;
        repeat (19) @(negedge iClk);
        busRead(2'd0, d);
        check("bounce_edge20_pre", d, 16'h0000);
        busRead(2'd0, d);
        check("bounce_edge20_post", d, 16'h0001);
        busRead(2'd1, d);
        check("bounce_edge_once", d, 16'h0001);

        // Clean change to 0x155.
        sw = 10'h155;
        repeat (19) @(negedge iClk);
        busRead(2'd0, d);
        check("clean_pre", d, 16'h0001);
        busRead(2'd0, d);
        check("clean_data", d, 16'h0155);
        busRead(2'd1, d);
        check("clean_edge", d, 16'h0155);
        check("clean_irq_masked", {15'd0, irq}, 16'd0);

        // Interrupt masking and W1C.
        busWrite(2'd2, 16'h0001);
        check("irq_reg_delay", {15'd0, irq}, 16'd0);
        @(negedge iClk);
        check("irq_on", {15'd0, irq}, 16'd1);
        busWrite(2'd1, 16'h0001);
        check("irq_clear_delay", {15'd0, irq}, 16'd1);
        @(negedge iClk);
        check("irq_off", {15'd0, irq}, 16'd0);
        busRead(2'd1, d);
        check("w1c_edge", d, 16'h0154);

        // W1C clear of bit0 lands on the commit edge that sets bit0.
        sw = 10'h154;
        repeat (19) @(negedge iClk);
        busWrite(2'd1, 16'h0001);
        busRead(2'd1, d);
        check("collision_set_wins", d, 16'h0155);
        busRead(2'd0, d);
        check("collision_data", d, 16'h0154);
        check("collision_irq", {15'd0, irq}, 16'd1);

        // Reset in the middle of a 0x3FF settle window.
        sw = 10'h3FF;
        repeat (10) @(negedge iClk);
        #2 iReset_n = 1'b0;
        @(negedge iClk);
        check("in_reset_rdata", bus.oReaddata, 16'h0000);
        check("in_reset_irq", {15'd0, irq}, 16'd0);
        #2 iReset_n = 1'b1;
        busRead(2'd3, d);
        check("post_reset_status", d, 16'h0000);
        busRead(2'd0, d);
        check("post_reset_data", d, 16'h0000);
        busRead(2'd1, d);
        check("post_reset_edge", d, 16'h0000);
        busRead(2'd2, d);
        check("post_reset_mask", d, 16'h0000);
        repeat (15) @(negedge iClk);
        busRead(2'd0, d);
        check("post_reset_edge20_pre", d, 16'h0000);
        busRead(2'd0, d);
        check("post_reset_edge20_post", d, 16'h03FF);

        // Short excursion that returns to the committed level.
        sw = '0;
        #2 iReset_n = 1'b0;
        @(negedge iClk);
        #2 iReset_n = 1'b1;
        repeat (3) @(negedge iClk);
        sw = 10'h001;
        repeat (4) @(negedge iClk);
        busRead(2'd3, d);
        check("abort_status_settle", d, 16'h0003);
        sw = '0;
        repeat (30) @(negedge iClk);
        busRead(2'd0, d);
        check("abort_data", d, 16'h0000);
        busRead(2'd1, d);
        check("abort_edge", d, 16'h0000);
        busRead(2'd3, d);
        check("abort_status_idle", d, 16'h0000);

        repeat (2) @(negedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
